// File: rtl/axi_xbar_pkg.sv
// Shared definitions for the AXI address-channel crossbar: default widths,
// FSM state encoding and the default slave address map.
package axi_xbar_pkg;

  localparam int NUM_M_DEF     = 3;
  localparam int NUM_S_DEF     = 6;
  localparam int ID_BITS_DEF   = 4;
  localparam int IDS_BITS_DEF  = 8;
  localparam int ADDR_BITS_DEF = 32;
  localparam int LEN_BITS_DEF  = 4;
  localparam int SIZE_BITS_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_ERR  = 2'd2
  } ar_state_e;

  // Slave index order: 0 ROM, 1 IM, 2 DM, 3 DMA, 4 WDT, 5 DRAM (index 0 rightmost).
  localparam logic [5:0][31:0] S_BASE_DEF = {
    32'h2000_0000,  // DRAM 0x2000_0000..0x201F_FFFF
    32'h1001_0000,  // WDT
    32'h1002_0000,  // DMA
    32'h0002_0000,  // DM
    32'h0001_0000,  // IM
    32'h0000_0000   // ROM
  };

  localparam logic [5:0][31:0] S_MASK_DEF = {
    32'hFFE0_0000,  // 2 MiB window
    32'hFFFF_0000,
    32'hFFFF_0000,
    32'hFFFF_0000,
    32'hFFFF_0000,
    32'hFFFF_0000   // 64 KiB windows
  };

  // Width of a master index; at least one bit so a single master still has a pointer.
  function automatic int ptr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_ar_xbar_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap.
// Shared with the write-address path.
module rr_arbiter
  import axi_xbar_pkg::*;
#(
  parameter int NUM_M = 3,
  parameter int PTR_W = ptr_bits(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NUM_M-1:0] grant,
  output logic [PTR_W-1:0] grant_idx
);

  // Scan NUM_M candidates starting at ptr; the first asserted request wins.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_M; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_M);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/axi_ar_xbar_rr.sv
// Read-address crossbar stage: round-robin picks one master, the request is
// registered, decoded against the address map and presented to exactly one
// slave, or to the decode-error responder when no slave claims it.
module axi_ar_xbar_rr
  import axi_xbar_pkg::*;
#(
  parameter int NUM_M     = NUM_M_DEF,
  parameter int NUM_S     = NUM_S_DEF,
  parameter int ID_BITS   = ID_BITS_DEF,
  parameter int IDS_BITS  = IDS_BITS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int LEN_BITS  = LEN_BITS_DEF,
  parameter int SIZE_BITS = SIZE_BITS_DEF,
  parameter logic [NUM_S-1:0][ADDR_BITS-1:0] S_BASE = S_BASE_DEF,
  parameter logic [NUM_S-1:0][ADDR_BITS-1:0] S_MASK = S_MASK_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_M*ID_BITS-1:0]   arid_m,
  input  logic [NUM_M*ADDR_BITS-1:0] araddr_m,
  input  logic [NUM_M*LEN_BITS-1:0]  arlen_m,
  input  logic [NUM_M*SIZE_BITS-1:0] arsize_m,
  input  logic [NUM_M*2-1:0]         arburst_m,
  input  logic [NUM_M-1:0]           arvalid_m,
  output logic [NUM_M-1:0]           arready_m,
  output logic [IDS_BITS-1:0]        arid_s,
  output logic [ADDR_BITS-1:0]       araddr_s,
  output logic [LEN_BITS-1:0]        arlen_s,
  output logic [SIZE_BITS-1:0]       arsize_s,
  output logic [1:0]                 arburst_s,
  output logic [NUM_S-1:0]           arvalid_s,
  input  logic [NUM_S-1:0]           arready_s,
  output logic                       decerr_valid,
  output logic [IDS_BITS-1:0]        decerr_id,
  output logic [LEN_BITS-1:0]        decerr_len,
  input  logic                       decerr_ready
);

  localparam int TAG_BITS = IDS_BITS - ID_BITS;
  localparam int PTR_W    = ptr_bits(NUM_M);

  ar_state_e                state_reg, state_next;
  logic [PTR_W-1:0]         rr_ptr_reg;
  logic                     active_reg;
  logic [NUM_S-1:0]         sel_reg;
  logic [IDS_BITS-1:0]      id_reg;
  logic [ADDR_BITS-1:0]     addr_reg;
  logic [LEN_BITS-1:0]      len_reg;
  logic [SIZE_BITS-1:0]     size_reg;
  logic [1:0]               burst_reg;

  logic [ID_BITS-1:0]       id_arr    [NUM_M];
  logic [ADDR_BITS-1:0]     addr_arr  [NUM_M];
  logic [LEN_BITS-1:0]      len_arr   [NUM_M];
  logic [SIZE_BITS-1:0]     size_arr  [NUM_M];
  logic [1:0]               burst_arr [NUM_M];

  logic [NUM_M-1:0]         grant_oh;
  logic [PTR_W-1:0]         grant_idx;
  logic                     accept;
  logic [ADDR_BITS-1:0]     grant_addr;
  logic [NUM_S-1:0]         hit_raw;
  logic [NUM_S-1:0]         hit_oh;
  logic [TAG_BITS-1:0]      tag_oh;

  generate
    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_unpack
      assign id_arr[gi]    = arid_m[gi*ID_BITS +: ID_BITS];
      assign addr_arr[gi]  = araddr_m[gi*ADDR_BITS +: ADDR_BITS];
      assign len_arr[gi]   = arlen_m[gi*LEN_BITS +: LEN_BITS];
      assign size_arr[gi]  = arsize_m[gi*SIZE_BITS +: SIZE_BITS];
      assign burst_arr[gi] = arburst_m[gi*2 +: 2];
    end
  endgenerate

  rr_arbiter #(
    .NUM_M (NUM_M),
    .PTR_W (PTR_W)
  ) u_arb (
    .req       (arvalid_m),
    .ptr       (rr_ptr_reg),
    .grant     (grant_oh),
    .grant_idx (grant_idx)
  );

  // Grants are only offered from IDLE, and not in the first cycle out of reset.
  assign accept     = (state_reg == ST_IDLE) && active_reg && (|arvalid_m);
  assign arready_m  = accept ? grant_oh : '0;
  assign grant_addr = addr_arr[grant_idx];
  assign tag_oh     = TAG_BITS'(1) << grant_idx;

  generate
    for (genvar gi = 0; gi < NUM_S; gi++) begin : g_decode
      assign hit_raw[gi] = (grant_addr & S_MASK[gi]) == S_BASE[gi];
    end
  endgenerate

  // Isolate the lowest set bit so overlapping windows resolve to the lowest slave.
  assign hit_oh = hit_raw & (~hit_raw + NUM_S'(1));

  // Next-state logic for the single in-flight request.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = (|hit_raw) ? ST_FWD : ST_ERR;
      ST_FWD:  if (|(sel_reg & arready_s)) state_next = ST_IDLE;
      ST_ERR:  if (decerr_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State, round-robin pointer and post-reset enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      rr_ptr_reg <= '0;
      active_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      active_reg <= 1'b1;
      if (accept) rr_ptr_reg <= PTR_W'((int'(grant_idx) + 1) % NUM_M);
    end
  end

  // Capture the granted request; held unchanged until the next grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_reg   <= '0;
      id_reg    <= '0;
      addr_reg  <= '0;
      len_reg   <= '0;
      size_reg  <= '0;
      burst_reg <= '0;
    end else if (accept) begin
      sel_reg   <= hit_oh;
      id_reg    <= {tag_oh, id_arr[grant_idx]};
      addr_reg  <= grant_addr;
      len_reg   <= len_arr[grant_idx];
      size_reg  <= size_arr[grant_idx];
      burst_reg <= burst_arr[grant_idx];
    end
  end

  assign arid_s       = id_reg;
  assign araddr_s     = addr_reg;
  assign arlen_s      = len_reg;
  assign arsize_s     = size_reg;
  assign arburst_s    = burst_reg;
  assign arvalid_s    = (state_reg == ST_FWD) ? sel_reg : '0;
  assign decerr_valid = (state_reg == ST_ERR);
  assign decerr_id    = id_reg;
  assign decerr_len   = len_reg;

endmodule

// File: tb/tb_axi_ar_xbar_rr.sv
// Bench for axi_ar_xbar_rr: directed scenarios plus a randomized run checked
// against an address-range / round-robin reference model.
module tb_axi_ar_xbar_rr;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] arid_m = '0;
  logic [95:0] araddr_m = '0;
  logic [11:0] arlen_m = '0;
  logic [8:0]  arsize_m = '0;
  logic [5:0]  arburst_m = '0;
  logic [2:0]  arvalid_m = '0;
  logic [2:0]  arready_m;
  logic [7:0]  arid_s;
  logic [31:0] araddr_s;
  logic [3:0]  arlen_s;
  logic [2:0]  arsize_s;
  logic [1:0]  arburst_s;
  logic [5:0]  arvalid_s;
  logic [5:0]  arready_s = '0;
  logic        decerr_valid;
  logic [7:0]  decerr_id;
  logic [3:0]  decerr_len;
  logic        decerr_ready = 1'b0;

  // Second instance with S3 aliased onto S0's window.
  logic [11:0] o_arid_m = '0;
  logic [95:0] o_araddr_m = '0;
  logic [2:0]  o_arvalid_m = '0;
  logic [2:0]  o_arready_m;
  logic [7:0]  o_arid_s;
  logic [31:0] o_araddr_s;
  logic [3:0]  o_arlen_s;
  logic [2:0]  o_arsize_s;
  logic [1:0]  o_arburst_s;
  logic [5:0]  o_arvalid_s;
  logic [5:0]  o_arready_s = '0;
  logic        o_decerr_valid;
  logic [7:0]  o_decerr_id;
  logic [3:0]  o_decerr_len;

  localparam logic [5:0][31:0] OVL_BASE = {32'h2000_0000, 32'h1001_0000, 32'h0000_0000,
                                           32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [5:0][31:0] OVL_MASK = {32'hFFE0_0000, 32'hFFFF_0000, 32'hFFFF_0000,
                                           32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_ar_xbar_rr dut (
    .clk(clk), .rst(rst),
    .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
    .arburst_m(arburst_m), .arvalid_m(arvalid_m), .arready_m(arready_m),
    .arid_s(arid_s), .araddr_s(araddr_s), .arlen_s(arlen_s), .arsize_s(arsize_s),
    .arburst_s(arburst_s), .arvalid_s(arvalid_s), .arready_s(arready_s),
    .decerr_valid(decerr_valid), .decerr_id(decerr_id), .decerr_len(decerr_len),
    .decerr_ready(decerr_ready)
  );

  axi_ar_xbar_rr #(.S_BASE(OVL_BASE), .S_MASK(OVL_MASK)) dut_ovl (
    .clk(clk), .rst(rst),
    .arid_m(o_arid_m), .araddr_m(o_araddr_m), .arlen_m(12'h0), .arsize_m(9'h0),
    .arburst_m(6'h0), .arvalid_m(o_arvalid_m), .arready_m(o_arready_m),
    .arid_s(o_arid_s), .araddr_s(o_araddr_s), .arlen_s(o_arlen_s), .arsize_s(o_arsize_s),
    .arburst_s(o_arburst_s), .arvalid_s(o_arvalid_s), .arready_s(o_arready_s),
    .decerr_valid(o_decerr_valid), .decerr_id(o_decerr_id), .decerr_len(o_decerr_len),
    .decerr_ready(1'b1)
  );

  // Reference address map expressed as inclusive ranges.
  function automatic int model_decode(input logic [31:0] a);
    if (a <= 32'h0000_FFFF) return 0;
    if (a >= 32'h0001_0000 && a <= 32'h0001_FFFF) return 1;
    if (a >= 32'h0002_0000 && a <= 32'h0002_FFFF) return 2;
    if (a >= 32'h1002_0000 && a <= 32'h1002_FFFF) return 3;
    if (a >= 32'h1001_0000 && a <= 32'h1001_FFFF) return 4;
    if (a >= 32'h2000_0000 && a <= 32'h201F_FFFF) return 5;
    return -1;
  endfunction

  // Reference round robin: first valid master from ptr upward, wrapping.
  function automatic int model_grant(input logic [2:0] v, input int ptr);
    for (int k = 0; k < 3; k++) begin
      if (v[(ptr + k) % 3]) return (ptr + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000 + ($urandom & 32'hFFFF);
      1: return 32'h0001_0000 + ($urandom & 32'hFFFF);
      2: return 32'h0002_0000 + ($urandom & 32'hFFFF);
      3: return 32'h1002_0000 + ($urandom & 32'hFFFF);
      4: return 32'h1001_0000 + ($urandom & 32'hFFFF);
      5: return 32'h2000_0000 + ($urandom & 32'h1F_FFFF);
      6: return 32'h3000_0000 + ($urandom & 32'hFFFF);
      default: return 32'h0003_0000 + ($urandom & 32'hFFFF);
    endcase
  endfunction

  task automatic set_master(input int m, input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len);
    arid_m[m*4 +: 4]     = id;
    araddr_m[m*32 +: 32] = addr;
    arlen_m[m*4 +: 4]    = len;
    arsize_m[m*3 +: 3]   = 3'd2;
    arburst_m[m*2 +: 2]  = 2'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; arvalid_m = '0; arready_s = '0; decerr_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_master(0, 4'h3, 32'h0001_0000, 4'h1);
    arvalid_m = 3'b111;
    repeat (2) @(negedge clk);
    #1;
    total++; if (arready_m !== 3'b000) begin bad++; $display("FAIL reset_arready: got %b want 000", arready_m); end
    total++; if (arvalid_s !== 6'b0) begin bad++; $display("FAIL reset_arvalid_s: got %b want 0", arvalid_s); end
    total++; if (decerr_valid !== 1'b0) begin bad++; $display("FAIL reset_decerr_valid: got %b want 0", decerr_valid); end
    total++; if ({arid_s, araddr_s, arlen_s} !== 44'h0) begin bad++; $display("FAIL reset_payload: got %h want 0", {arid_s, araddr_s, arlen_s}); end
    arvalid_m = '0;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    $display("test_reset checked");
  endtask

  task automatic test_single_map();
    set_master(0, 4'h5, 32'h0001_0040, 4'd3);
    arvalid_m = 3'b001; arready_s = 6'b000010;
    #1;
    total++; if (arready_m !== 3'b001) begin bad++; $display("FAIL single_arready: got %b want 001", arready_m); end
    @(negedge clk);
    arvalid_m = '0;
    #1;
    total++; if (arvalid_s !== 6'b000010) begin bad++; $display("FAIL single_arvalid_s: got %b want 000010", arvalid_s); end
    total++; if (arid_s !== 8'h15) begin bad++; $display("FAIL single_arid: got %h want 15", arid_s); end
    total++; if (araddr_s !== 32'h0001_0040 || arlen_s !== 4'd3) begin bad++; $display("FAIL single_payload: got %h/%0d want 00010040/3", araddr_s, arlen_s); end
    total++; if (arready_m !== 3'b000) begin bad++; $display("FAIL single_busy_arready: got %b want 000", arready_m); end
    @(negedge clk);
    arready_s = '0;
    #1;
    total++; if (arvalid_s !== 6'b0) begin bad++; $display("FAIL single_done: got %b want 0", arvalid_s); end
    set_master(1, 4'h2, 32'h0000_0010, 4'd0);
    arvalid_m = 3'b010;
    #1;
    total++; if (arready_m !== 3'b010) begin bad++; $display("FAIL single_back_idle: got %b want 010", arready_m); end
    arvalid_m = '0;  // withdrawn before the edge: no handshake
    @(negedge clk); #1;
    total++; if (arvalid_s !== 6'b0 || decerr_valid !== 1'b0) begin bad++; $display("FAIL single_withdraw: got %b/%b want 0/0", arvalid_s, decerr_valid); end
    $display("test_single_map checked");
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_id;
    do_reset();
    set_master(0, 4'h8, 32'h0000_0100, 4'd1);
    set_master(1, 4'h9, 32'h0001_0200, 4'd2);
    set_master(2, 4'hA, 32'h0002_0300, 4'd3);
    arvalid_m = 3'b111; arready_s = 6'h3F;
    for (int n = 0; n < 6; n++) begin
      #1;
      total++; if (arready_m !== 3'(1 << (n % 3))) begin bad++; $display("FAIL rr_grant%0d: got %b want %b", n, arready_m, 3'(1 << (n % 3))); end
      @(negedge clk); #1;
      exp_id = {4'(1 << (n % 3)), 4'(8 + n % 3)};
      total++; if (arid_s !== exp_id || arvalid_s !== 6'(1 << (n % 3))) begin bad++; $display("FAIL rr_fwd%0d: got %h/%b want %h/%b", n, arid_s, arvalid_s, exp_id, 6'(1 << (n % 3))); end
      @(negedge clk);
    end
    arvalid_m = '0; arready_s = '0;
    @(negedge clk);
    $display("test_round_robin checked");
  endtask

  task automatic test_back_pressure();
    set_master(2, 4'h3, 32'h0002_0100, 4'd2);
    arvalid_m = 3'b100; arready_s = '0;
    @(negedge clk);
    set_master(0, 4'h1, 32'h0000_0000, 4'd0);
    set_master(1, 4'h1, 32'h0001_0000, 4'd0);
    for (int k = 0; k < 5; k++) begin
      arvalid_m = 3'b011;
      #1;
      total++; if (arvalid_s !== 6'b000100 || araddr_s !== 32'h0002_0100 || arid_s !== 8'h43) begin bad++; $display("FAIL bp_hold%0d: got %b/%h/%h want 000100/00020100/43", k, arvalid_s, araddr_s, arid_s); end
      total++; if (arready_m !== 3'b000) begin bad++; $display("FAIL bp_arready%0d: got %b want 000", k, arready_m); end
      @(negedge clk);
    end
    arvalid_m = '0; arready_s = 6'b000100;
    @(negedge clk);
    arready_s = '0;
    #1;
    total++; if (arvalid_s !== 6'b0) begin bad++; $display("FAIL bp_release: got %b want 0", arvalid_s); end
    $display("test_back_pressure checked");
  endtask

  task automatic test_decode_error();
    set_master(1, 4'hA, 32'h3000_0000, 4'd7);
    arvalid_m = 3'b010; decerr_ready = 1'b0; arready_s = 6'h3F;
    #1;
    total++; if (arready_m !== 3'b010) begin bad++; $display("FAIL derr_grant: got %b want 010", arready_m); end
    @(negedge clk);
    arvalid_m = '0;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++; if (decerr_valid !== 1'b1 || decerr_id !== 8'h2A || decerr_len !== 4'd7) begin bad++; $display("FAIL derr_hold%0d: got %b/%h/%0d want 1/2a/7", k, decerr_valid, decerr_id, decerr_len); end
      total++; if (arvalid_s !== 6'b0) begin bad++; $display("FAIL derr_no_slave%0d: got %b want 0", k, arvalid_s); end
      @(negedge clk);
    end
    decerr_ready = 1'b1;
    @(negedge clk);
    decerr_ready = 1'b0; arready_s = '0;
    #1;
    total++; if (decerr_valid !== 1'b0) begin bad++; $display("FAIL derr_release: got %b want 0", decerr_valid); end
    set_master(0, 4'h0, 32'h0, 4'd0);
    arvalid_m = 3'b001;
    #1;
    total++; if (arready_m !== 3'b001) begin bad++; $display("FAIL derr_idle: got %b want 001", arready_m); end
    arvalid_m = '0;
    @(negedge clk);
    $display("test_decode_error checked");
  endtask

  task automatic test_reset_mid_fwd();
    set_master(0, 4'h1, 32'h2000_1000, 4'd0);
    set_master(1, 4'h2, 32'h0001_0000, 4'd0);
    arvalid_m = 3'b001; arready_s = '0;
    @(negedge clk);
    arvalid_m = '0;
    #1;
    total++; if (arvalid_s !== 6'b100000) begin bad++; $display("FAIL rstfwd_pre: got %b want 100000", arvalid_s); end
    #2 rst = 1'b0;
    #1;
    total++; if (arvalid_s !== 6'b0 || arid_s !== 8'h0) begin bad++; $display("FAIL rstfwd_clear: got %b/%h want 0/00", arvalid_s, arid_s); end
    @(negedge clk);
    rst = 1'b1; arvalid_m = 3'b011;
    @(negedge clk); #1;
    total++; if (arready_m !== 3'b001) begin bad++; $display("FAIL rstfwd_ptr: got %b want 001", arready_m); end
    arvalid_m = '0;
    @(negedge clk);
    $display("test_reset_mid_fwd checked");
  endtask

  task automatic test_overlap();
    o_arid_m[3:0] = 4'h7; o_araddr_m[31:0] = 32'h0000_0100;
    o_arvalid_m = 3'b001; o_arready_s = '0;
    #1;
    total++; if (o_arready_m !== 3'b001) begin bad++; $display("FAIL ovl_grant: got %b want 001", o_arready_m); end
    @(negedge clk);
    o_arvalid_m = '0;
    #1;
    total++; if (o_arvalid_s !== 6'b000001 || o_arid_s !== 8'h17) begin bad++; $display("FAIL ovl_select: got %b/%h want 000001/17", o_arvalid_s, o_arid_s); end
    o_arready_s = 6'h3F;
    @(negedge clk); #1;
    total++; if (o_arvalid_s !== 6'b0) begin bad++; $display("FAIL ovl_done: got %b want 0", o_arvalid_s); end
    o_arready_s = '0;
    $display("test_overlap checked");
  endtask

  task automatic test_random();
    int          mstate;   // 0 idle, 1 forwarding, 2 decode error
    int          ptr;
    int          exp_slave;
    int          g;
    int          granted;
    int          grants [3];
    logic [7:0]  exp_id;
    logic [31:0] exp_addr;
    logic [8:0]  exp_misc;
    mstate = 0; ptr = 0; exp_slave = 0; exp_id = '0; exp_addr = '0; exp_misc = '0;
    grants = '{0, 0, 0};
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc != 0) @(negedge clk);
      for (int m = 0; m < 3; m++) begin
        if (!arvalid_m[m] && $urandom_range(0, 2) == 0) begin
          set_master(m, 4'($urandom_range(0, 15)), rand_addr(), 4'($urandom_range(0, 15)));
          arsize_m[m*3 +: 3]  = 3'($urandom_range(0, 7));
          arburst_m[m*2 +: 2] = 2'($urandom_range(0, 2));
          arvalid_m[m] = 1'b1;
        end
      end
      arready_s    = 6'($urandom);
      decerr_ready = 1'($urandom_range(0, 1));
      #1;
      granted = -1;
      case (mstate)
        0: begin
          g = model_grant(arvalid_m, ptr);
          total++; if (arready_m !== ((g >= 0) ? 3'(1 << g) : 3'b000)) begin bad++; $display("FAIL rnd_grant c%0d: got %b ptr %0d valid %b", cyc, arready_m, ptr, arvalid_m); end
          total++; if (arvalid_s !== 6'b0 || decerr_valid !== 1'b0) begin bad++; $display("FAIL rnd_idle c%0d: got %b/%b want 0/0", cyc, arvalid_s, decerr_valid); end
          if (g >= 0) begin
            granted   = g;
            grants[g] = grants[g] + 1;
            exp_id    = {4'(1 << g), arid_m[g*4 +: 4]};
            exp_addr  = araddr_m[g*32 +: 32];
            exp_misc  = {arlen_m[g*4 +: 4], arsize_m[g*3 +: 3], arburst_m[g*2 +: 2]};
            exp_slave = model_decode(exp_addr);
            mstate    = (exp_slave >= 0) ? 1 : 2;
            ptr       = (g + 1) % 3;
          end
        end
        1: begin
          total++; if (arvalid_s !== 6'(1 << exp_slave) || arready_m !== 3'b000) begin bad++; $display("FAIL rnd_fwd c%0d: got %b/%b want %b/000", cyc, arvalid_s, arready_m, 6'(1 << exp_slave)); end
          total++; if (arid_s !== exp_id || araddr_s !== exp_addr || {arlen_s, arsize_s, arburst_s} !== exp_misc) begin bad++; $display("FAIL rnd_payload c%0d: got %h/%h/%h want %h/%h/%h", cyc, arid_s, araddr_s, {arlen_s, arsize_s, arburst_s}, exp_id, exp_addr, exp_misc); end
          if (arready_s[exp_slave]) mstate = 0;
        end
        default: begin
          total++; if (decerr_valid !== 1'b1 || decerr_id !== exp_id || decerr_len !== exp_misc[8:5]) begin bad++; $display("FAIL rnd_err c%0d: got %b/%h/%0d want 1/%h/%0d", cyc, decerr_valid, decerr_id, decerr_len, exp_id, exp_misc[8:5]); end
          total++; if (arvalid_s !== 6'b0 || arready_m !== 3'b000) begin bad++; $display("FAIL rnd_err_quiet c%0d: got %b/%b want 0/000", cyc, arvalid_s, arready_m); end
          if (decerr_ready) mstate = 0;
        end
      endcase
      @(posedge clk); #1;
      if (granted >= 0) arvalid_m[granted] = 1'b0;
    end
    arvalid_m = '0; arready_s = '0; decerr_ready = 1'b0;
    for (int m = 0; m < 3; m++) begin
      total++; if (grants[m] < 10) begin bad++; $display("FAIL rnd_starve m%0d: got %0d grants want >=10", m, grants[m]); end
    end
    $display("test_random checked: grants %0d %0d %0d", grants[0], grants[1], grants[2]);
  endtask

  initial begin
    test_reset();
    test_single_map();
    test_round_robin();
    test_back_pressure();
    test_decode_error();
    test_reset_mid_fwd();
    test_overlap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
